id_ex_stage: RTL

- ID/EX pipeline register and operand-forwarding stage of the RISC-V pipeline.
- Sits directly upstream of the ALU: it latches decoded ID fields and drives the ALU operands and op code.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, stalls ID and inserts bubbles.

---
 rtl/id_ex_stage_pkg.sv | 43 ++++
 rtl/id_ex_stage_fwd_mux.sv | 38 +++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, bubble control values
// and the operand-forwarding select encoding.
package id_ex_stage_pkg;

    // ALU operation codes, same encoding the ALU consumes
    typedef enum logic [5:0] {
        ADD_OP  = 6'h00,
        SUB_OP  = 6'h01,
        AND_OP  = 6'h02,
        OR_OP   = 6'h03,
        XOR_OP  = 6'h04,
        SLL_OP  = 6'h05,
        SRL_OP  = 6'h06,
        SRA_OP  = 6'h07,
        SLT_OP  = 6'h08,
        SLTU_OP = 6'h09
    } alu_op_e;

    // Control values of a bubble (a NOP that writes nothing and touches no memory)
    localparam logic    BUBBLE_VALID  = 1'b0;
    localparam logic    BUBBLE_WR_EN  = 1'b0;
    localparam logic    BUBBLE_MEM_RD = 1'b0;
    localparam logic    BUBBLE_MEM_WR = 1'b0;
    localparam alu_op_e BUBBLE_OP     = ADD_OP;

    // Where a forwarded operand comes from
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // MEM holds the younger result, so it wins over WB
    function automatic fwd_sel_e fwd_select(input logic hit_mem, input logic hit_wb);
        if (hit_mem) begin
            return FWD_MEM;
        end else if (hit_wb) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: compares the source address
// against the MEM and WB destinations and picks the freshest value. x0 is never
// forwarded because its value is architecturally fixed at zero.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rs_data,
    input  logic [RADDR_W-1:0] rd_addr_mem,
    input  logic               wr_en_mem,
    input  logic [XLEN-1:0]    res_mem,
    input  logic [RADDR_W-1:0] rd_addr_wb,
    input  logic               wr_en_wb,
    input  logic [XLEN-1:0]    res_wb,
    output logic [XLEN-1:0]    fwd_data
);

    logic     hit_mem;
    logic     hit_wb;
    fwd_sel_e sel;

    // Address compare against each producer stage, then 3:1 select
    always_comb begin
        hit_mem  = wr_en_mem && (rd_addr_mem != '0) && (rd_addr_mem == rs_addr);
        hit_wb   = wr_en_wb  && (rd_addr_wb  != '0) && (rd_addr_wb  == rs_addr);
        sel      = fwd_select(hit_mem, hit_wb);
        fwd_data = rs_data;
        case (sel)
            FWD_MEM: fwd_data = res_mem;
            FWD_WB:  fwd_data = res_wb;
            default: fwd_data = rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Latches decoded ID fields, drives the ALU operands/op code, stalls ID and
// inserts a bubble when an instruction needs the result of the load in EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_stall_i,
    input  logic               flush_i,
    input  logic               valid_id_i,
    input  logic [XLEN-1:0]    pc_id_i,
    input  logic [RADDR_W-1:0] rs1_addr_id_i,
    input  logic [RADDR_W-1:0] rs2_addr_id_i,
    input  logic               rs1_used_id_i,
    input  logic               rs2_used_id_i,
    input  logic [XLEN-1:0]    rs1_data_id_i,
    input  logic [XLEN-1:0]    rs2_data_id_i,
    input  logic [XLEN-1:0]    imm_id_i,
    input  logic               use_imm_id_i,
    input  logic               use_pc_id_i,
    input  logic [OP_W-1:0]    op_alu_id_i,
    input  logic [RADDR_W-1:0] rd_addr_id_i,
    input  logic               wr_en_id_i,
    input  logic               mem_rd_id_i,
    input  logic               mem_wr_id_i,
    input  logic [RADDR_W-1:0] rd_addr_mem_i,
    input  logic               wr_en_mem_i,
    input  logic [XLEN-1:0]    res_mem_i,
    input  logic [RADDR_W-1:0] rd_addr_wb_i,
    input  logic               wr_en_wb_i,
    input  logic [XLEN-1:0]    res_wb_i,
    output logic               stall_id_o,
    output logic [XLEN-1:0]    opr_a_alu_o,
    output logic [XLEN-1:0]    opr_b_alu_o,
    output logic [OP_W-1:0]    op_alu_o,
    output logic [XLEN-1:0]    store_data_ex_o,
    output logic               valid_ex_o,
    output logic               wr_en_ex_o,
    output logic               mem_rd_ex_o,
    output logic               mem_wr_ex_o,
    output logic [XLEN-1:0]    pc_ex_o,
    output logic [RADDR_W-1:0] rd_addr_ex_o
);

    localparam logic [OP_W-1:0] BUBBLE_OP_W = OP_W'(BUBBLE_OP);

    logic [RADDR_W-1:0] rs1_addr_ex;
    logic [RADDR_W-1:0] rs2_addr_ex;
    logic [XLEN-1:0]    rs1_data_ex;
    logic [XLEN-1:0]    rs2_data_ex;
    logic [XLEN-1:0]    imm_ex;
    logic               use_imm_ex;
    logic               use_pc_ex;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;
    logic               load_use;
    logic               load_bubble;

    // Hazard detection: the ID instruction reads the register the EX load writes
    always_comb begin
        load_use = mem_rd_ex_o && valid_ex_o && (rd_addr_ex_o != '0) && valid_id_i &&
                   ((rs1_used_id_i && (rs1_addr_id_i == rd_addr_ex_o)) ||
                    (rs2_used_id_i && (rs2_addr_id_i == rd_addr_ex_o)));
        load_bubble = flush_i || load_use || !valid_id_i;
        // A flush kills the dependent instruction, so it must not be held back;
        // reset forces the stall low so IF/ID restarts together with this stage
        stall_id_o  = rst_n && (mem_stall_i || (load_use && !flush_i));
    end

    // Pipeline register: hold on memory stall, else bubble or capture ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex_o   <= BUBBLE_VALID;
            wr_en_ex_o   <= BUBBLE_WR_EN;
            mem_rd_ex_o  <= BUBBLE_MEM_RD;
            mem_wr_ex_o  <= BUBBLE_MEM_WR;
            op_alu_o     <= BUBBLE_OP_W;
            pc_ex_o      <= '0;
            rd_addr_ex_o <= '0;
            rs1_addr_ex  <= '0;
            rs2_addr_ex  <= '0;
            rs1_data_ex  <= '0;
            rs2_data_ex  <= '0;
            imm_ex       <= '0;
            use_imm_ex   <= 1'b0;
            use_pc_ex    <= 1'b0;
        end else if (mem_stall_i) begin
            valid_ex_o   <= valid_ex_o;
        end else if (load_bubble) begin
            valid_ex_o   <= BUBBLE_VALID;
            wr_en_ex_o   <= BUBBLE_WR_EN;
            mem_rd_ex_o  <= BUBBLE_MEM_RD;
            mem_wr_ex_o  <= BUBBLE_MEM_WR;
            op_alu_o     <= BUBBLE_OP_W;
            pc_ex_o      <= '0;
            rd_addr_ex_o <= '0;
            rs1_addr_ex  <= '0;
            rs2_addr_ex  <= '0;
            rs1_data_ex  <= '0;
            rs2_data_ex  <= '0;
            imm_ex       <= '0;
            use_imm_ex   <= 1'b0;
            use_pc_ex    <= 1'b0;
        end else begin
            valid_ex_o   <= 1'b1;
            wr_en_ex_o   <= wr_en_id_i;
            mem_rd_ex_o  <= mem_rd_id_i;
            mem_wr_ex_o  <= mem_wr_id_i;
            op_alu_o     <= op_alu_id_i;
            pc_ex_o      <= pc_id_i;
            rd_addr_ex_o <= rd_addr_id_i;
            rs1_addr_ex  <= rs1_addr_id_i;
            rs2_addr_ex  <= rs2_addr_id_i;
            rs1_data_ex  <= rs1_data_id_i;
            rs2_data_ex  <= rs2_data_id_i;
            imm_ex       <= imm_id_i;
            use_imm_ex   <= use_imm_id_i;
            use_pc_ex    <= use_pc_id_i;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs_addr     (rs1_addr_ex),
        .rs_data     (rs1_data_ex),
        .rd_addr_mem (rd_addr_mem_i),
        .wr_en_mem   (wr_en_mem_i),
        .res_mem     (res_mem_i),
        .rd_addr_wb  (rd_addr_wb_i),
        .wr_en_wb    (wr_en_wb_i),
        .res_wb      (res_wb_i),
        .fwd_data    (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs_addr     (rs2_addr_ex),
        .rs_data     (rs2_data_ex),
        .rd_addr_mem (rd_addr_mem_i),
        .wr_en_mem   (wr_en_mem_i),
        .res_mem     (res_mem_i),
        .rd_addr_wb  (rd_addr_wb_i),
        .wr_en_wb    (wr_en_wb_i),
        .res_wb      (res_wb_i),
        .fwd_data    (fwd_rs2)
    );

    // ALU operand selection; stores always take the forwarded rs2
    always_comb begin
        opr_a_alu_o     = use_pc_ex  ? pc_ex_o : fwd_rs1;
        opr_b_alu_o     = use_imm_ex ? imm_ex  : fwd_rs2;
        store_data_ex_o = fwd_rs2;
    end

endmodule
